packet_inject_ctrl: RTL and testbench

PACKET_INJECT_CTRL -- requirements
Module: packet_inject_ctrl

---
 rtl/packet_inject_ctrl.sv | 124 ++++++++++++
 tb/tb_packet_inject_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_inject_ctrl.sv
// rtl/packet_inject_ctrl.sv - packet-table injection sequencer
// Fetches up to DEPTH packets in order, presents each until acked, with MIN_GAP idle cycles between.
module packet_inject_ctrl #(
  parameter int PKT_W   = 38,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 20,
  parameter int MIN_GAP = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] NUM_PKT,
  input  logic              PAUSE,
  output logic [ADDR_W-1:0] FETCH_ADDR,
  input  logic [PKT_W-1:0]  FETCH_DATA,
  output logic [PKT_W-1:0]  PKT_OUT,
  output logic              PKT_VALID,
  input  logic              PKT_ACK,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] SENT_CNT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_C  = ADDR_W'(DEPTH);
  localparam logic [3:0]        GAP_LAST = 4'(MIN_GAP - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   run_len_q, run_len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   sent_q, sent_d;
  logic [PKT_W-1:0]    pkt_q, pkt_d;
  logic                valid_q, valid_d;
  logic [3:0]          gap_q, gap_d;
  logic [ADDR_W-1:0]   sent_inc;

  assign sent_inc = sent_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      run_len_q <= '0;
      addr_q    <= '0;
      sent_q    <= '0;
      pkt_q     <= '0;
      valid_q   <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      addr_q    <= addr_d;
      sent_q    <= sent_d;
      pkt_q     <= pkt_d;
      valid_q   <= valid_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    addr_d    = addr_q;
    sent_d    = sent_q;
    pkt_d     = pkt_q;
    valid_d   = valid_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          // Clamping the run to the table size keeps FETCH_ADDR inside the table.
          run_len_d = (NUM_PKT > DEPTH_C) ? DEPTH_C : NUM_PKT;
          addr_d    = '0;
          sent_d    = '0;
          state_d   = (NUM_PKT == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (!PAUSE) begin
          pkt_d   = FETCH_DATA;
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (PKT_ACK && valid_q) begin
          valid_d = 1'b0;
          sent_d  = sent_inc;
          addr_d  = addr_q + 1'b1;
          gap_d   = '0;
          if (sent_inc == run_len_q) state_d = S_FIN;
          else if (MIN_GAP > 0)      state_d = S_GAP;
          else                       state_d = S_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_LOAD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state_q != S_IDLE);
    DONE       = (state_q == S_FIN);
    PKT_VALID  = valid_q;
    PKT_OUT    = pkt_q;
    FETCH_ADDR = addr_q;
    SENT_CNT   = sent_q;
  end

endmodule

// File: tb/tb_packet_inject_ctrl.sv
// tb/tb_packet_inject_ctrl.sv - self-checking bench for packet_inject_ctrl
module tb_packet_inject_ctrl;
  localparam int PKT_W   = 38;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 20;
  localparam int MIN_GAP = 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic              PAUSE = 1'b0;
  logic              PKT_ACK = 1'b0;
  logic [ADDR_W-1:0] NUM_PKT = '0;
  logic [ADDR_W-1:0] FETCH_ADDR, SENT_CNT;
  logic [PKT_W-1:0]  FETCH_DATA, PKT_OUT;
  logic              PKT_VALID, BUSY, DONE;

  logic [PKT_W-1:0]  tbl [0:31];
  assign FETCH_DATA = tbl[FETCH_ADDR];

  always #5 CLK = ~CLK;

  packet_inject_ctrl #(.PKT_W(PKT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
    .CLK(CLK), .RST(RST), .START(START), .NUM_PKT(NUM_PKT), .PAUSE(PAUSE),
    .FETCH_ADDR(FETCH_ADDR), .FETCH_DATA(FETCH_DATA), .PKT_OUT(PKT_OUT),
    .PKT_VALID(PKT_VALID), .PKT_ACK(PKT_ACK), .BUSY(BUSY), .DONE(DONE),
    .SENT_CNT(SENT_CNT)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Timestamp model: a run is a list of packets; each fetch may happen no earlier than fetch_at.
  bit               m_run, m_fin, m_valid, chk_en;
  int               m_len, m_addr, m_sent, fetch_at, cyc;
  logic [PKT_W-1:0] m_pkt;

  int               done_cnt, valid_cnt, busy_cnt, start_c, first_v, poison_seen;
  int               acc_t[$];
  logic [PKT_W-1:0] acc_d[$];

  task automatic clr_mon();
    done_cnt = 0; valid_cnt = 0; busy_cnt = 0; poison_seen = 0;
    start_c = -1; first_v = -1;
    acc_t.delete(); acc_d.delete();
  endtask

  initial begin
    m_run = 0; m_fin = 0; m_valid = 0; chk_en = 0;
    m_len = 0; m_addr = 0; m_sent = 0; fetch_at = 0; cyc = 0; m_pkt = '0;
    clr_mon();
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        chk("busy",       BUSY,       m_run | m_fin);
        chk("done",       DONE,       m_fin);
        chk("pkt_valid",  PKT_VALID,  m_valid);
        chk("fetch_addr", FETCH_ADDR, m_addr);
        chk("sent_cnt",   SENT_CNT,   m_sent);
        chk("pkt_out",    PKT_OUT,    m_pkt);
      end
      if (DONE) done_cnt++;
      if (BUSY) busy_cnt++;
      if (PKT_VALID) valid_cnt++;
      if (START && !BUSY && !RST && start_c < 0) start_c = cyc;
      if (PKT_VALID && first_v < 0) first_v = cyc;
      if (PKT_VALID && PKT_ACK) begin acc_t.push_back(cyc); acc_d.push_back(PKT_OUT); end
      if (PKT_VALID && PKT_OUT[PKT_W-1 -: 6] == 6'h3F) poison_seen++;
      // Advance the model across the coming rising edge using the inputs it will sample.
      if (RST) begin
        m_run = 0; m_fin = 0; m_valid = 0; m_pkt = '0; m_addr = 0; m_sent = 0; chk_en = 1;
      end else if (m_fin) begin
        m_fin = 0;
      end else if (!m_run) begin
        if (START) begin
          m_len  = (int'(NUM_PKT) < DEPTH) ? int'(NUM_PKT) : DEPTH;
          m_addr = 0; m_sent = 0;
          if (NUM_PKT == 0) m_fin = 1;
          else begin m_run = 1; fetch_at = cyc + 1; end
        end
      end else if (m_valid) begin
        if (PKT_ACK) begin
          m_valid = 0; m_sent++; m_addr++;
          if (m_sent == m_len) begin m_run = 0; m_fin = 1; end
          else fetch_at = cyc + 1 + MIN_GAP;
        end
      end else if (cyc >= fetch_at && !PAUSE) begin
        m_valid = 1; m_pkt = tbl[m_addr];
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_run(input int n);
    NUM_PKT = ADDR_W'(n); START = 1'b1; tick(); START = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    for (int i = 0; i < bound && done_cnt == 0; i++) tick();
    chk(name, done_cnt != 0, 1);
  endtask

  task automatic wait_valid(input int bound, input string name);
    for (int i = 0; i < bound && !PKT_VALID; i++) tick();
    chk(name, PKT_VALID, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},  BUSY, 0);
    chk({tag, "_done"},  DONE, 0);
    chk({tag, "_valid"}, PKT_VALID, 0);
    chk({tag, "_addr"},  FETCH_ADDR, 0);
    chk({tag, "_sent"},  SENT_CNT, 0);
    chk({tag, "_pkt"},   PKT_OUT, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++)
      tbl[i] = (i < DEPTH) ? {6'(i), 32'($urandom())} : {6'h3F, 32'(i)};
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    chk_reset_outs("reset");

    // Four packets, ack tied high: 3-cycle spacing, first valid two cycles after START.
    PKT_ACK = 1'b1; clr_mon();
    start_run(4);
    wait_done(60, "s1_timeout");
    chk("s1_count", acc_t.size(), 4);
    for (int i = 0; i < acc_t.size() && i < 4; i++) chk("s1_data", acc_d[i], tbl[i]);
    for (int i = 0; i + 1 < acc_t.size() && i < 3; i++) chk("s1_spacing", acc_t[i+1] - acc_t[i], 3);
    chk("s1_valid_cycles", valid_cnt, 4);
    chk("s1_first_latency", first_v - start_c, 2);
    chk("s1_done_pulses", done_cnt, 1);
    chk("s1_sent", SENT_CNT, 4);

    // Ack withheld for five cycles: packet held, address frozen.
    PKT_ACK = 1'b0; clr_mon();
    start_run(2);
    wait_valid(10, "s2_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("s2_hold_pkt", PKT_OUT, tbl[0]);
      chk("s2_hold_valid", PKT_VALID, 1);
      chk("s2_hold_addr", FETCH_ADDR, 0);
      tick();
    end
    PKT_ACK = 1'b1;
    wait_done(40, "s2_timeout");
    chk("s2_sent", SENT_CNT, 2);
    chk("s2_count", acc_t.size(), 2);

    // Empty run.
    clr_mon();
    start_run(0);
    wait_done(10, "s3_timeout");
    chk("s3_busy_cycles", busy_cnt, 1);
    chk("s3_done_pulses", done_cnt, 1);
    chk("s3_valid_cycles", valid_cnt, 0);
    chk("s3_sent", SENT_CNT, 0);

    // Oversized request clamps to the table depth.
    clr_mon();
    start_run(31);
    wait_done(200, "s4_timeout");
    chk("s4_count", acc_t.size(), DEPTH);
    for (int i = 0; i < acc_t.size() && i < DEPTH; i++) chk("s4_data", acc_d[i], tbl[i]);
    chk("s4_poison", poison_seen, 0);
    chk("s4_sent", SENT_CNT, DEPTH);

    // Pause across the gap plus an ignored second START.
    clr_mon();
    start_run(3);
    wait_valid(10, "s5_valid_timeout");
    tick();
    PAUSE = 1'b1; START = 1'b1; NUM_PKT = ADDR_W'(1);
    tick();
    START = 1'b0;
    repeat (3) tick();
    PAUSE = 1'b0;
    wait_done(60, "s5_timeout");
    chk("s5_count", acc_t.size(), 3);
    if (acc_t.size() >= 2) chk("s5_paused_spacing", acc_t[1] - acc_t[0], 6);
    chk("s5_sent", SENT_CNT, 3);

    // Reset while packet 3 of 5 is on offer.
    PKT_ACK = 1'b0; clr_mon();
    start_run(5);
    for (int k = 0; k < 2; k++) begin
      wait_valid(10, "s6_valid_timeout");
      PKT_ACK = 1'b1; tick(); PKT_ACK = 1'b0;
    end
    wait_valid(10, "s6_valid3_timeout");
    chk("s6_sent_before_rst", SENT_CNT, 2);
    RST = 1'b1; tick(); RST = 1'b0;
    chk_reset_outs("s6_rst");
    repeat (5) tick();
    chk("s6_no_done", done_cnt, 0);
    clr_mon(); PKT_ACK = 1'b1;
    start_run(1);
    wait_done(20, "s6_timeout");
    chk("s6_count", acc_t.size(), 1);
    if (acc_t.size() >= 1) chk("s6_data", acc_d[0], tbl[0]);

    // Randomized traffic against the model.
    repeat (3000) begin
      RST     = ($urandom_range(0, 199) == 0);
      START   = ($urandom_range(0, 5) == 0);
      NUM_PKT = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom()) : ADDR_W'($urandom_range(0, 6));
      PAUSE   = ($urandom_range(0, 3) == 0);
      PKT_ACK = ($urandom_range(0, 2) != 0);
      tick();
    end
    RST = 1'b0; START = 1'b0; PAUSE = 1'b0; PKT_ACK = 1'b1;
    repeat (100) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
